// File: rtl/req_grant_agent.sv
// req_grant_agent: requester-side agent for a 3-client request/grant arbiter.
// Each client holds one queued job, requests the arbiter, runs a burst of
// granted beats (not necessarily contiguous) and releases its request. Grants
// are also checked for protocol violations, which set a sticky error flag.
module req_grant_agent #(
    parameter int unsigned N     = 3,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     job_valid,
    input  logic [LEN_W-1:0] job_len,
    input  logic [N-1:0]     grants,
    output logic [N-1:0]     requests,
    output logic [N-1:0]     job_ready,
    output logic [N-1:0]     xfer,
    output logic [N-1:0]     busy,
    output logic [N-1:0]     done,
    output logic             err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StXfer = 2'd2
    } state_e;

    localparam logic [LEN_W:0] RemOne  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [N-1:0]   GrantOne = {{(N-1){1'b0}}, 1'b1};

    state_e         r_state [N];
    state_e         w_state_nxt [N];
    logic [LEN_W:0] r_rem [N];
    logic [LEN_W:0] w_rem_nxt [N];

    logic [N-1:0]   r_requests;
    logic [N-1:0]   r_busy;
    logic [N-1:0]   r_job_ready;
    logic [N-1:0]   r_done;
    logic           r_err;

    logic [N-1:0]   w_done_nxt;
    logic [N-1:0]   w_requests_nxt;
    logic [N-1:0]   w_busy_nxt;
    logic [N-1:0]   w_job_ready_nxt;
    logic [LEN_W:0] w_len_eff;
    logic           w_multi_grant;
    logic           w_unreq_grant;

    // A zero-length job is treated as a single-beat burst.
    assign w_len_eff = (job_len == '0) ? RemOne : {1'b0, job_len};

    // Protocol checks: more than one grant bit, or a grant to a non-requester.
    assign w_multi_grant = |(grants & (grants - GrantOne));
    assign w_unreq_grant = |(grants & ~r_requests);

    // Per-client next state, remaining-beat count and completion pulse.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            w_state_nxt[i] = r_state[i];
            w_rem_nxt[i]   = r_rem[i];
            w_done_nxt[i]  = 1'b0;
            unique case (r_state[i])
                StIdle: begin
                    if (job_valid[i]) begin
                        w_rem_nxt[i]   = w_len_eff;
                        w_state_nxt[i] = StReq;
                    end
                end
                // The first grant while in StReq is already a beat.
                StReq, StXfer: begin
                    if (grants[i]) begin
                        w_rem_nxt[i] = r_rem[i] - RemOne;
                        if (r_rem[i] == RemOne) begin
                            w_state_nxt[i] = StIdle;
                            w_done_nxt[i]  = 1'b1;
                        end else begin
                            w_state_nxt[i] = StXfer;
                        end
                    end
                end
                default: begin
                    w_state_nxt[i] = StIdle;
                end
            endcase
        end
    end

    // Output flags decoded from the next state so they come straight off flops.
    always_comb begin
        w_requests_nxt  = '0;
        w_busy_nxt      = '0;
        w_job_ready_nxt = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_requests_nxt[i]  = (w_state_nxt[i] != StIdle);
            w_busy_nxt[i]      = (w_state_nxt[i] == StXfer);
            w_job_ready_nxt[i] = (w_state_nxt[i] == StIdle);
        end
    end

    // Per-client state and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N); i++) begin
            if (!reset) begin
                r_state[i] <= StIdle;
                r_rem[i]   <= '0;
            end else begin
                r_state[i] <= w_state_nxt[i];
                r_rem[i]   <= w_rem_nxt[i];
            end
        end
    end

    // Registered outputs and sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_requests  <= '0;
            r_busy      <= '0;
            r_job_ready <= '1;
            r_done      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_requests  <= w_requests_nxt;
            r_busy      <= w_busy_nxt;
            r_job_ready <= w_job_ready_nxt;
            r_done      <= w_done_nxt;
            r_err       <= r_err | w_multi_grant | w_unreq_grant;
        end
    end

    assign requests  = r_requests;
    assign busy      = r_busy;
    assign job_ready = r_job_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign xfer      = grants & r_busy;

endmodule

// File: tb/tb_req_grant_agent.sv
// tb_req_grant_agent: directed scenarios plus randomized traffic, all checked
// against a job-level reference model (beats left per client, started flag).
module tb_req_grant_agent;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  job_valid;
    logic [3:0]  job_len;
    logic [2:0]  grants;
    logic [2:0]  requests;
    logic [2:0]  job_ready;
    logic [2:0]  xfer;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic        err;

    req_grant_agent #(
        .N     (3),
        .LEN_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .job_valid (job_valid),
        .job_len   (job_len),
        .grants    (grants),
        .requests  (requests),
        .job_ready (job_ready),
        .xfer      (xfer),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: beats still owed per client (0 = no job held),
    // whether the burst has had its first beat, and the registered flags.
    int         m_left [3];
    bit         m_started [3];
    logic [2:0] m_done;
    logic       m_err;

    wire [12:0] dut_out = {requests, busy, job_ready, done, err};

    function automatic logic [2:0] m_req_v();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (m_left[i] != 0);
        return r;
    endfunction

    function automatic logic [2:0] m_busy_v();
        logic [2:0] b;
        for (int i = 0; i < 3; i++) b[i] = m_started[i];
        return b;
    endfunction

    function automatic logic [12:0] m_out();
        return {m_req_v(), m_busy_v(), ~m_req_v(), m_done, m_err};
    endfunction

    // Lowest-index requester wins.
    function automatic logic [2:0] prio(input logic [2:0] r);
        return r & (~r + 3'b001);
    endfunction

    // One clock edge: the model consumes the inputs that were stable before it.
    task automatic tick();
        logic [2:0] old_req;
        old_req = m_req_v();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_left[i]    = 0;
                m_started[i] = 0;
            end
            m_done = 3'b000;
            m_err  = 1'b0;
        end else begin
            if ($countones(grants) > 1 || (grants & ~old_req) != 3'b000) m_err = 1'b1;
            for (int i = 0; i < 3; i++) begin
                m_done[i] = 1'b0;
                if (m_left[i] == 0) begin
                    if (job_valid[i]) begin
                        m_left[i]    = (job_len == 4'd0) ? 1 : int'(job_len);
                        m_started[i] = 0;
                    end
                end else if (grants[i]) begin
                    m_left[i]    = m_left[i] - 1;
                    m_started[i] = 1;
                    if (m_left[i] == 0) begin
                        m_started[i] = 0;
                        m_done[i]    = 1'b1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        job_valid = 3'b000;
        job_len   = 4'd0;
        grants    = 3'b000;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (dut_out !== {3'b000, 3'b000, 3'b111, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected %b", dut_out,
                     {3'b000, 3'b000, 3'b111, 3'b000, 1'b0});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_job();
        int req_cycles = 0;
        int done_cnt   = 0;
        job_valid = 3'b001;
        job_len   = 4'd3;
        tick();
        job_valid = 3'b000;
        for (int c = 0; c < 8; c++) begin
            grants = m_req_v() & 3'b001;
            #1;
            n_checks++;
            if (xfer !== (grants & m_busy_v())) begin
                n_fail++;
                $display("FAIL single_xfer: got %b expected %b", xfer, grants & m_busy_v());
            end
            if (requests[0] === 1'b1) req_cycles++;
            tick();
            if (done === 3'b001) done_cnt++;
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL single_cycle: got %b expected %b", dut_out, m_out());
            end
        end
        grants = 3'b000;
        n_checks++;
        if (req_cycles != 3 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL single_counts: got req=%0d done=%0d expected req=3 done=1",
                     req_cycles, done_cnt);
        end
        n_checks++;
        if ({requests, job_ready} !== 6'b000_111) begin
            n_fail++;
            $display("FAIL single_final: got %b expected %b", {requests, job_ready}, 6'b000_111);
        end
    endtask

    task automatic test_len_zero();
        job_valid = 3'b100;
        job_len   = 4'd0;
        tick();
        idle_inputs();
        grants = 3'b100;
        tick();
        grants = 3'b000;
        n_checks++;
        if ({done, requests, err} !== {3'b100, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL len_zero: got done=%b req=%b err=%b expected done=100 req=000 err=0",
                     done, requests, err);
        end
        tick();
        n_checks++;
        if (dut_out !== m_out()) begin
            n_fail++;
            $display("FAIL len_zero_after: got %b expected %b", dut_out, m_out());
        end
    endtask

    task automatic test_preempt();
        bit pat [7] = '{1, 1, 0, 0, 0, 1, 1};
        job_valid = 3'b001;
        job_len   = 4'd4;
        tick();
        idle_inputs();
        for (int k = 0; k < 7; k++) begin
            grants = pat[k] ? 3'b001 : 3'b000;
            tick();
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL preempt_cycle%0d: got %b expected %b", k, dut_out, m_out());
            end
            if (k >= 1 && k <= 4) begin
                n_checks++;
                if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL preempt_gap%0d: got busy=%b done=%b expected busy=1 done=0",
                             k, busy[0], done[0]);
                end
            end
        end
        grants = 3'b000;
        n_checks++;
        if ({done, requests} !== 6'b001_000) begin
            n_fail++;
            $display("FAIL preempt_done: got %b expected %b", {done, requests}, 6'b001_000);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] req_seq [$];
        int         done_seq [$];
        job_valid = 3'b111;
        job_len   = 4'd2;
        tick();
        idle_inputs();
        req_seq.push_back(requests);
        for (int c = 0; c < 10; c++) begin
            grants = prio(m_req_v());
            #1;
            n_checks++;
            if (xfer !== (grants & m_busy_v())) begin
                n_fail++;
                $display("FAIL b2b_xfer: got %b expected %b", xfer, grants & m_busy_v());
            end
            tick();
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL b2b_cycle: got %b expected %b", dut_out, m_out());
            end
            if (requests !== req_seq[$]) req_seq.push_back(requests);
            for (int i = 0; i < 3; i++) if (done[i] === 1'b1) done_seq.push_back(i);
        end
        grants = 3'b000;
        n_checks++;
        if (req_seq.size() != 4 || req_seq[0] !== 3'b111 || req_seq[1] !== 3'b110 ||
            req_seq[2] !== 3'b100 || req_seq[3] !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_req_order: got %0d distinct values, expected 111,110,100,000",
                     req_seq.size());
        end
        n_checks++;
        if (done_seq.size() != 3 || done_seq[0] != 0 || done_seq[1] != 1 || done_seq[2] != 2)
        begin
            n_fail++;
            $display("FAIL b2b_done_order: got %0d pulses, expected order 0,1,2", done_seq.size());
        end
    endtask

    task automatic test_protocol_error();
        // Grant to a client that is not requesting.
        grants = 3'b100;
        tick();
        grants = 3'b000;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_unrequested: got %b expected 1", err);
        end
        tick();
        tick();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 1", err);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: got %b expected 0", err);
        end
        // Multi-hot grant to two requesting clients; both still take the beat.
        job_valid = 3'b011;
        job_len   = 4'd2;
        tick();
        idle_inputs();
        grants = 3'b011;
        tick();
        n_checks++;
        if ({err, busy} !== 4'b1_011) begin
            n_fail++;
            $display("FAIL err_multi: got err=%b busy=%b expected err=1 busy=011", err, busy);
        end
        for (int c = 0; c < 4; c++) begin
            grants = prio(m_req_v());
            tick();
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL err_drain: got %b expected %b", dut_out, m_out());
            end
        end
        grants = 3'b000;
    endtask

    task automatic test_reset_midburst();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        job_valid = 3'b010;
        job_len   = 4'd5;
        tick();
        idle_inputs();
        grants = 3'b010;
        tick();
        tick();
        grants = 3'b000;
        reset  = 1'b0;
        tick();
        n_checks++;
        if (dut_out !== {3'b000, 3'b000, 3'b111, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_midburst: got %b expected %b", dut_out,
                     {3'b000, 3'b000, 3'b111, 3'b000, 1'b0});
        end
        reset = 1'b1;
        tick();
        job_valid = 3'b010;
        job_len   = 4'd2;
        tick();
        idle_inputs();
        grants = 3'b010;
        tick();
        tick();
        grants = 3'b000;
        n_checks++;
        if ({done, requests, err} !== {3'b010, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_newjob: got done=%b req=%b err=%b expected 010 000 0",
                     done, requests, err);
        end
    endtask

    task automatic test_random();
        int pick;
        int r;
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 59) != 0);
            job_valid = 3'($urandom);
            job_len   = 4'($urandom);
            r         = $urandom_range(0, 19);
            pick      = $urandom_range(0, 2);
            if (r == 0) grants = 3'($urandom);
            else if (r < 12) grants = m_req_v() & (3'b001 << pick);
            else grants = 3'b000;
            #1;
            n_checks++;
            if (xfer !== (grants & m_busy_v())) begin
                n_fail++;
                $display("FAIL rand_xfer%0d: got %b expected %b", c, xfer, grants & m_busy_v());
            end
            tick();
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: got %b expected %b", c, dut_out, m_out());
            end
        end
        reset = 1'b1;
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_left[i]    = 0;
            m_started[i] = 0;
        end
        m_done = 3'b000;
        m_err  = 1'b0;
        reset  = 1'b0;
        idle_inputs();
        test_reset();
        test_single_job();
        test_len_zero();
        test_preempt();
        test_back_to_back();
        test_protocol_error();
        test_reset_midburst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
